// File: rtl/ccc_dyncfg_ctrl_pkg.sv
// Shared definitions for the CCC dynamic-reconfiguration sequencer.
// The AHB register block decodes status with the same state encoding.
package ccc_dyncfg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_UPDATE    = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_RUN       = 3'd4,
    ST_ERROR     = 3'd5
  } ccc_state_t;

  localparam int CFG_W_DEFAULT = 81;

  function automatic logic state_busy(input ccc_state_t st);
    return st inside {ST_LOAD, ST_SHIFT, ST_UPDATE};
  endfunction

  function automatic logic state_accepts_start(input ccc_state_t st);
    return st inside {ST_WAIT_LOCK, ST_RUN, ST_ERROR};
  endfunction

endpackage

// File: rtl/ccc_dyncfg_ctrl_lock_filter.sv
// PLL lock qualifier: 2-flop synchroniser followed by a consecutive-cycle
// stability counter that only runs while the sequencer is waiting for lock.
module ccc_lock_filter
  import ccc_dyncfg_ctrl_pkg::*;
#(
  parameter int LOCK_STABLE = 256,
  parameter int CNT_W       = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic lock_async,
  input  logic count_en,
  output logic lock_s,
  output logic lock_ok
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] stable_cnt;

  // Counter saturates at its terminal value so lock_ok cannot wrap away.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync1 <= lock_async;
      sync2 <= sync1;
      if (!count_en || !sync2) begin
        stable_cnt <= '0;
      end else if (stable_cnt != STABLE_LAST) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  assign lock_s  = sync2;
  assign lock_ok = sync2 && (stable_cnt == STABLE_LAST);

endmodule

// File: rtl/ccc_dyncfg_ctrl.sv
// MSS_CCC PLL dynamic reconfiguration sequencer: serial config load,
// lock qualification with timeout, and fabric reset release / lock-loss watch.
module ccc_dyncfg_ctrl
  import ccc_dyncfg_ctrl_pkg::*;
#(
  parameter int CFG_W        = CFG_W_DEFAULT,
  parameter int SCLK_DIV     = 4,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 256,
  parameter int CNT_W        = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [CFG_W-1:0] CFG_DATA,
  input  logic             CFG_START,
  output logic             CFG_BUSY,
  output logic             CFG_DONE,
  output logic             CFG_ERR,
  output logic             LOCK_LOST,
  output logic             PLL_SCLK,
  output logic             PLL_SDIN,
  output logic             PLL_SSHIFT,
  output logic             PLL_SUPDATE,
  input  logic             PLL_LOCK,
  output logic             FAB_RST
);

  localparam logic [CNT_W-1:0] DIV_LAST     = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CFG_W - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  ccc_state_t       state, state_nxt;
  logic [CFG_W-1:0] shreg, shreg_nxt, shreg_shifted;
  logic [CNT_W-1:0] div_cnt, div_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_nxt;
  logic [CNT_W-1:0] timeout_cnt, timeout_nxt;
  logic sclk_q, sclk_nxt, sdin_q, sdin_nxt;
  logic sshift_q, sshift_nxt, supdate_q, supdate_nxt;
  logic fab_rst_q, fab_rst_nxt, err_q, err_nxt, lost_q, lost_nxt;
  logic reconfig_q, reconfig_nxt;
  logic lock_s, lock_ok, accept, div_end, sclk_fall;

  ccc_lock_filter #(
    .LOCK_STABLE (LOCK_STABLE),
    .CNT_W       (CNT_W)
  ) u_lock_filter (
    .clock      (HCLK),
    .reset      (HRESET),
    .lock_async (PLL_LOCK),
    .count_en   (state == ST_WAIT_LOCK),
    .lock_s     (lock_s),
    .lock_ok    (lock_ok)
  );

  // A qualifying lock outranks a same-cycle START so DONE is never orphaned.
  assign accept        = CFG_START && state_accepts_start(state)
                         && !(state == ST_WAIT_LOCK && lock_ok);
  assign div_end       = (div_cnt == DIV_LAST);
  assign sclk_fall     = div_end && sclk_q;
  assign shreg_shifted = shreg >> 1;

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    div_nxt      = '0;
    bit_nxt      = bit_cnt;
    timeout_nxt  = '0;
    sclk_nxt     = sclk_q;
    sdin_nxt     = sdin_q;
    sshift_nxt   = sshift_q;
    supdate_nxt  = supdate_q;
    fab_rst_nxt  = fab_rst_q;
    err_nxt      = err_q;
    lost_nxt     = lost_q;
    reconfig_nxt = reconfig_q;

    if (accept) begin
      state_nxt    = ST_LOAD;
      shreg_nxt    = CFG_DATA;
      fab_rst_nxt  = 1'b1;
      err_nxt      = 1'b0;
      lost_nxt     = 1'b0;
      reconfig_nxt = 1'b1;
    end else begin
      unique case (state)
        ST_LOAD: begin
          sshift_nxt = 1'b1;
          sdin_nxt   = shreg[0];
          sclk_nxt   = 1'b0;
          bit_nxt    = '0;
          state_nxt  = ST_SHIFT;
        end
        ST_SHIFT: begin
          div_nxt = div_end ? '0 : div_cnt + CNT_W'(1);
          if (div_end) sclk_nxt = ~sclk_q;
          if (sclk_fall) begin
            if (bit_cnt == BIT_LAST) begin
              sshift_nxt  = 1'b0;
              supdate_nxt = 1'b1;
              sdin_nxt    = 1'b0;
              state_nxt   = ST_UPDATE;
            end else begin
              shreg_nxt = shreg_shifted;
              sdin_nxt  = shreg_shifted[0];
              bit_nxt   = bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_UPDATE: begin
          div_nxt = div_end ? '0 : div_cnt + CNT_W'(1);
          if (div_end) sclk_nxt = ~sclk_q;
          if (sclk_fall) begin
            supdate_nxt = 1'b0;
            state_nxt   = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_ok) begin
            state_nxt    = ST_RUN;
            reconfig_nxt = 1'b0;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end else begin
            timeout_nxt = timeout_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          // Fabric reset releases one cycle after entering RUN.
          if (!lock_s) begin
            state_nxt   = ST_WAIT_LOCK;
            fab_rst_nxt = 1'b1;
            lost_nxt    = 1'b1;
          end else begin
            fab_rst_nxt = 1'b0;
          end
        end
        ST_ERROR: fab_rst_nxt = 1'b1;
        default:  state_nxt   = ST_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= ST_WAIT_LOCK;
      shreg       <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      timeout_cnt <= '0;
      sclk_q      <= 1'b0;
      sdin_q      <= 1'b0;
      sshift_q    <= 1'b0;
      supdate_q   <= 1'b0;
      fab_rst_q   <= 1'b1;
      err_q       <= 1'b0;
      lost_q      <= 1'b0;
      reconfig_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      div_cnt     <= div_nxt;
      bit_cnt     <= bit_nxt;
      timeout_cnt <= timeout_nxt;
      sclk_q      <= sclk_nxt;
      sdin_q      <= sdin_nxt;
      sshift_q    <= sshift_nxt;
      supdate_q   <= supdate_nxt;
      fab_rst_q   <= fab_rst_nxt;
      err_q       <= err_nxt;
      lost_q      <= lost_nxt;
      reconfig_q  <= reconfig_nxt;
    end
  end

  assign CFG_BUSY    = state_busy(state);
  assign CFG_DONE    = (state == ST_WAIT_LOCK) && lock_ok && reconfig_q;
  assign CFG_ERR     = err_q;
  assign LOCK_LOST   = lost_q;
  assign PLL_SCLK    = sclk_q;
  assign PLL_SDIN    = sdin_q;
  assign PLL_SSHIFT  = sshift_q;
  assign PLL_SUPDATE = supdate_q;
  assign FAB_RST     = fab_rst_q;

endmodule

// File: tb/tb_ccc_dyncfg_ctrl.sv
// Self-checking bench for ccc_dyncfg_ctrl: serial-word capture, lock timing,
// timeout, lock loss and mid-shift reset, with randomized config words.
module tb_ccc_dyncfg_ctrl;

  localparam int W     = 8;
  localparam int DIV   = 2;
  localparam int LT    = 100;
  localparam int LS    = 16;
  localparam int CNT_W = 16;

  logic         HCLK;
  logic         HRESET;
  logic [W-1:0] CFG_DATA;
  logic         CFG_START;
  logic         CFG_BUSY, CFG_DONE, CFG_ERR, LOCK_LOST;
  logic         PLL_SCLK, PLL_SDIN, PLL_SSHIFT, PLL_SUPDATE;
  logic         PLL_LOCK;
  logic         FAB_RST;

  int checks   = 0;
  int failures = 0;

  int sshift_cyc  = 0;
  int supdate_cyc = 0;
  int glitches    = 0;
  bit bits_q[$];
  logic prev_sclk = 1'b0;
  logic held_sdin = 1'b0;

  ccc_dyncfg_ctrl #(
    .CFG_W        (W),
    .SCLK_DIV     (DIV),
    .LOCK_TIMEOUT (LT),
    .LOCK_STABLE  (LS),
    .CNT_W        (CNT_W)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .CFG_DATA    (CFG_DATA),
    .CFG_START   (CFG_START),
    .CFG_BUSY    (CFG_BUSY),
    .CFG_DONE    (CFG_DONE),
    .CFG_ERR     (CFG_ERR),
    .LOCK_LOST   (LOCK_LOST),
    .PLL_SCLK    (PLL_SCLK),
    .PLL_SDIN    (PLL_SDIN),
    .PLL_SSHIFT  (PLL_SSHIFT),
    .PLL_SUPDATE (PLL_SUPDATE),
    .PLL_LOCK    (PLL_LOCK),
    .FAB_RST     (FAB_RST)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Serial-port observer: one bit captured per SCLK rise while SSHIFT is high.
  always @(negedge HCLK) begin
    if (PLL_SSHIFT) sshift_cyc++;
    if (PLL_SUPDATE) supdate_cyc++;
    if (PLL_SCLK && !prev_sclk && PLL_SSHIFT) bits_q.push_back(PLL_SDIN);
    if (PLL_SCLK && prev_sclk && (PLL_SDIN != held_sdin)) glitches++;
    if (PLL_SCLK && !prev_sclk) held_sdin = PLL_SDIN;
    prev_sclk = PLL_SCLK;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Counts edges until the fabric reset releases and how many DONE pulses occur meanwhile.
  task automatic waitRelease(input string tag, input int exp_edges, input int exp_done);
    int n  = 0;
    int dn = 0;
    while (FAB_RST && n < 4 * LT) begin
      tick();
      n++;
      if (CFG_DONE) dn++;
    end
    checkOutput({tag, "_release_edges"}, n, exp_edges);
    checkOutput({tag, "_done_pulses"}, dn, exp_done);
  endtask

  // One full reconfiguration; the expected word and timing come from the config rules.
  task automatic applyStimulus(input logic [W-1:0] data, input bit mid_start, input logic lock_after);
    int s_bits = bits_q.size();
    int s_sh   = sshift_cyc;
    int s_up   = supdate_cyc;
    int s_gl   = glitches;
    int busy_n = 1;
    logic [W-1:0] word = '0;
    CFG_DATA  = data;
    CFG_START = 1'b1;
    tick();
    CFG_START = 1'b0;
    CFG_DATA  = ~data;
    PLL_LOCK  = lock_after;
    checkOutput("accept_busy", CFG_BUSY, 1);
    checkOutput("accept_err_clear", CFG_ERR, 0);
    checkOutput("accept_lost_clear", LOCK_LOST, 0);
    checkOutput("accept_fab_rst", FAB_RST, 1);
    for (int k = 0; k < 2000 && CFG_BUSY; k++) begin
      CFG_START = mid_start && (busy_n == 10);
      tick();
      if (CFG_BUSY) busy_n++;
    end
    CFG_START = 1'b0;
    for (int i = 0; i < W && (s_bits + i) < bits_q.size(); i++) word[i] = bits_q[s_bits + i];
    checkOutput("busy_cycles", busy_n, 1 + 2 * DIV * W + 2 * DIV);
    checkOutput("sshift_cycles", sshift_cyc - s_sh, 2 * DIV * W);
    checkOutput("supdate_cycles", supdate_cyc - s_up, 2 * DIV);
    checkOutput("sclk_pulses", bits_q.size() - s_bits, W);
    checkOutput("sdin_word", word, data);
    checkOutput("sdin_stable", glitches - s_gl, 0);
    checkOutput("post_update_fab_rst", FAB_RST, 1);
  endtask

  initial begin
    int n;
    bit fab_low;
    int s_bits, s_up;

    HRESET    = 1'b1;
    PLL_LOCK  = 1'b1;
    CFG_START = 1'b0;
    CFG_DATA  = '0;
    repeat (3) tick();
    checkOutput("rst_fab_rst", FAB_RST, 1);
    checkOutput("rst_busy", CFG_BUSY, 0);
    checkOutput("rst_done", CFG_DONE, 0);
    checkOutput("rst_err", CFG_ERR, 0);
    checkOutput("rst_lost", LOCK_LOST, 0);
    checkOutput("rst_serial", {PLL_SCLK, PLL_SDIN, PLL_SSHIFT, PLL_SUPDATE}, 0);

    // Power-up lock: 2 sync stages, LS qualifying cycles, one cycle into RUN.
    $display("[TB] power-up lock release");
    HRESET = 1'b0;
    waitRelease("powerup", LS + 3, 0);

    $display("[TB] reconfiguration with 8'hA5");
    applyStimulus(8'hA5, 1'b0, 1'b1);
    waitRelease("cfg_a5", LS + 1, 1);

    $display("[TB] START ignored during shift");
    applyStimulus(W'($urandom()), 1'b1, 1'b1);
    waitRelease("cfg_midstart", LS + 1, 1);

    $display("[TB] lock timeout");
    applyStimulus(W'($urandom()), 1'b0, 1'b0);
    n = 0;
    fab_low = 1'b0;
    while (!CFG_ERR && n < LT + 50) begin
      tick();
      n++;
      if (!FAB_RST) fab_low = 1'b1;
    end
    checkOutput("timeout_edges", n, LT);
    checkOutput("timeout_fab_low_seen", fab_low, 0);
    repeat (5) tick();
    checkOutput("timeout_err_sticky", CFG_ERR, 1);
    checkOutput("timeout_fab_rst", FAB_RST, 1);
    PLL_LOCK = 1'b1;
    repeat (3) tick();
    applyStimulus(W'($urandom()), 1'b0, 1'b1);
    waitRelease("after_err", LS + 1, 1);

    $display("[TB] one-cycle lock drop in RUN");
    repeat (4) tick();
    PLL_LOCK = 1'b0;
    tick();
    n = 1;
    PLL_LOCK = 1'b1;
    while (!LOCK_LOST && n < 20) begin
      tick();
      n++;
    end
    checkOutput("lost_edges", n, 3);
    checkOutput("lost_fab_rst", FAB_RST, 1);
    waitRelease("relock", LS + 1, 0);
    checkOutput("lost_sticky", LOCK_LOST, 1);

    $display("[TB] randomized reconfigurations");
    for (int it = 0; it < 4; it++) begin
      applyStimulus(W'($urandom()), 1'($urandom_range(0, 1)), 1'b1);
      waitRelease("rand_cfg", LS + 1, 1);
    end

    $display("[TB] reset in the middle of a shift");
    s_up   = supdate_cyc;
    CFG_DATA  = W'($urandom());
    CFG_START = 1'b1;
    tick();
    CFG_START = 1'b0;
    s_bits = bits_q.size();
    n = 0;
    while ((bits_q.size() - s_bits) < 5 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("midrst_reached_bit", bits_q.size() - s_bits, 5);
    HRESET = 1'b1;
    tick();
    checkOutput("midrst_serial", {PLL_SCLK, PLL_SDIN, PLL_SSHIFT, PLL_SUPDATE}, 0);
    checkOutput("midrst_busy", CFG_BUSY, 0);
    checkOutput("midrst_fab_rst", FAB_RST, 1);
    checkOutput("midrst_flags", {CFG_DONE, CFG_ERR, LOCK_LOST}, 0);
    repeat (2) tick();
    checkOutput("midrst_no_update", supdate_cyc - s_up, 0);
    HRESET = 1'b0;
    waitRelease("midrst_relock", LS + 3, 0);
    checkOutput("midrst_no_update_after", supdate_cyc - s_up, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
